// File: rtl/rc_pwm_decoder_if.sv
// rc_pwm_decoder_if
// Bundles the receiver pulse input and the decoded motor-command outputs.
//   pwm_in      : raw receiver pulse (asynchronous to the decoder clock)
//   speed       : magnitude 0..255
//   direction   : 1 = reverse, 0 = forward/neutral
//   pulse_width : last accepted high time in ticks
//   valid       : one-cycle strobe on every accepted pulse
//   pulse_err   : one-cycle strobe on every rejected pulse
//   signal_lost : level, no accepted pulse for TIMEOUT ticks
// master = pulse source / command consumer, slave = decoder.
interface rc_pwm_decoder_if;
  logic        pwm_in;
  logic [7:0]  speed;
  logic        direction;
  logic [15:0] pulse_width;
  logic        valid;
  logic        pulse_err;
  logic        signal_lost;

  modport master (
    output pwm_in,
    input  speed, direction, pulse_width, valid, pulse_err, signal_lost
  );

  modport slave (
    input  pwm_in,
    output speed, direction, pulse_width, valid, pulse_err, signal_lost
  );
endinterface

// File: rtl/rc_pwm_decoder.sv
// rc_pwm_decoder
// Measures the high time of an RC receiver pulse in prescaled ticks and turns
// it into a speed/direction command. Out-of-range pulses raise pulse_err, and
// signal_lost is raised after TIMEOUT ticks without an accepted pulse.
// Ports:
//   clk_in   : system clock
//   reset_in : synchronous, active-high reset
//   bus      : rc_pwm_decoder_if.slave (pwm_in in, decoded command out)
module rc_pwm_decoder #(
  parameter int CLK_DIV      = 49,
  parameter int PULSE_MIN    = 800,
  parameter int PULSE_MAX    = 2200,
  parameter int PULSE_CENTER = 1500,
  parameter int DEADBAND     = 20,
  parameter int SCALE_SHIFT  = 1,
  parameter int TIMEOUT      = 25000
) (
  input  logic               clk_in,
  input  logic               reset_in,
  rc_pwm_decoder_if.slave    bus
);

  localparam int PW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  localparam logic [15:0]   MIN_W     = 16'(PULSE_MIN);
  localparam logic [15:0]   MAX_W     = 16'(PULSE_MAX);
  localparam logic [15:0]   CTR_W     = 16'(PULSE_CENTER);
  localparam logic [16:0]   DB17      = 17'(DEADBAND);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH} state_e;

  state_e          state_q, state_d;
  logic            sync0_q, s1_q, s1_dly_q;
  logic [1:0]      fill_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     width_q, width_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      speed_q, speed_d;
  logic            dir_q, dir_d;
  logic [15:0]     pw_q, pw_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            lost_q, lost_d;

  logic            rise, fall, tick, accept, in_range;
  logic [15:0]     width_fin;
  logic            neg;
  logic [16:0]     mag, beyond, scaled;
  logic [7:0]      conv_speed;
  logic            conv_dir;

  assign rise = ~s1_dly_q & s1_q;
  assign fall = s1_dly_q & ~s1_q;
  assign tick = (presc_q == PRESC_MAX);

  // Include the tick landing on the evaluation edge so an exact multiple of
  // the tick period measures exactly, not one short.
  assign width_fin = (tick && width_q != 16'hFFFF) ? width_q + 16'd1 : width_q;
  assign in_range  = (width_fin >= MIN_W) && (width_fin <= MAX_W);

  // Magnitude around center computed unsigned, sign kept separately.
  always_comb begin
    neg        = (width_fin < CTR_W);
    mag        = neg ? ({1'b0, CTR_W} - {1'b0, width_fin})
                     : ({1'b0, width_fin} - {1'b0, CTR_W});
    beyond     = mag - DB17;
    scaled     = beyond >> SCALE_SHIFT;
    conv_speed = 8'd0;
    conv_dir   = 1'b0;
    if (mag > DB17) begin
      conv_speed = (scaled > 17'd255) ? 8'hFF : scaled[7:0];
      conv_dir   = neg;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    width_d = width_q;
    tmo_d   = tmo_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    pw_d    = pw_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    lost_d  = lost_q;
    accept  = 1'b0;

    unique case (state_q)
      // fill_q holds off the exit until the synchronizer carries real line
      // samples; otherwise its reset zeros would make a line that is already
      // high look like a fresh rise.
      IDLE:  if (fill_q[1] && !s1_q) state_d = ARMED;
      ARMED: if (rise) begin
        presc_d = '0;
        width_d = '0;
        state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          state_d = ARMED;
          if (in_range) begin
            accept  = 1'b1;
            valid_d = 1'b1;
            speed_d = conv_speed;
            dir_d   = conv_dir;
            pw_d    = width_fin;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          width_d = width_fin;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accepted pulse beats a timeout landing in the same cycle.
    if (accept) begin
      tmo_d  = '0;
      lost_d = 1'b0;
    end else begin
      if (tick && tmo_q != TMO_MAX) tmo_d = tmo_q + TW'(1);
      if (tmo_d == TMO_MAX) begin
        lost_d  = 1'b1;
        speed_d = 8'd0;
        dir_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync0_q  <= 1'b0;
      s1_q     <= 1'b0;
      s1_dly_q <= 1'b0;
      fill_q   <= '0;
      state_q  <= IDLE;
      presc_q  <= '0;
      width_q  <= '0;
      tmo_q    <= '0;
      speed_q  <= '0;
      dir_q    <= 1'b0;
      pw_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      sync0_q  <= bus.pwm_in;
      s1_q     <= sync0_q;
      s1_dly_q <= s1_q;
      fill_q   <= {fill_q[0], 1'b1};
      state_q  <= state_d;
      presc_q  <= presc_d;
      width_q  <= width_d;
      tmo_q    <= tmo_d;
      speed_q  <= speed_d;
      dir_q    <= dir_d;
      pw_q     <= pw_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
    end
  end

  assign bus.speed       = speed_q;
  assign bus.direction   = dir_q;
  assign bus.pulse_width = pw_q;
  assign bus.valid       = valid_q;
  assign bus.pulse_err   = err_q;
  assign bus.signal_lost = lost_q;

endmodule

// File: tb/tb_rc_pwm_decoder.sv
// tb_rc_pwm_decoder
// Directed pulses with hand-computed commands. Two clocks per tick and a
// shortened timeout keep the run short; pulse thresholds are the defaults.
module tb_rc_pwm_decoder;
  localparam int CLK_DIV = 1;
  localparam int TMO     = 6000;
  localparam int GAP     = 50;

  logic clk_in = 1'b0;
  logic reset_in;
  rc_pwm_decoder_if bus();

  rc_pwm_decoder #(.CLK_DIV(CLK_DIV), .TIMEOUT(TMO)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int errs = 0, checks = 0;
  int vtot = 0, etot = 0, both = 0;

  always @(negedge clk_in) if (!reset_in) begin
    if (bus.valid) vtot++;
    if (bus.pulse_err) etot++;
    if (bus.valid && bus.pulse_err) both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (2 * n) @(negedge clk_in);
  endtask

  // High for exactly w ticks, then watch six edges for strobes.
  // i==0 is the first edge sampling the line low, so strobes belong at i==2.
  task automatic pulse(input int w, output int vcnt, output int ecnt, output int scyc);
    @(negedge clk_in) bus.pwm_in = 1'b1;
    repeat (2 * w) @(negedge clk_in);
    bus.pwm_in = 1'b0;
    vcnt = 0; ecnt = 0; scyc = -1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_in); #1;
      if (bus.valid)     begin vcnt++; scyc = i; end
      if (bus.pulse_err) begin ecnt++; scyc = i; end
    end
    ticks(GAP);
  endtask

  function automatic logic near(input logic [15:0] pw, input int w);
    return (int'(pw) >= w - 1) && (int'(pw) <= w + 1);
  endfunction

  task automatic good(input string tag, input int w, input int spd, input int dir);
    int v, e, c;
    pulse(w, v, e, c);
    chk({tag, "_valid"}, v, 1);
    chk({tag, "_err"},   e, 0);
    chk({tag, "_lat"},   c, 2);
    chk({tag, "_speed"}, bus.speed, spd);
    chk({tag, "_dir"},   bus.direction, dir);
    chk({tag, "_pw"},    near(bus.pulse_width, w), 1);
    chk({tag, "_lost"},  bus.signal_lost, 0);
  endtask

  task automatic bad(input string tag, input int w, input int spd, input int dir, input int pw);
    int v, e, c;
    pulse(w, v, e, c);
    chk({tag, "_valid"}, v, 0);
    chk({tag, "_err"},   e, 1);
    chk({tag, "_lat"},   c, 2);
    chk({tag, "_speed"}, bus.speed, spd);
    chk({tag, "_dir"},   bus.direction, dir);
    chk({tag, "_pw"},    near(bus.pulse_width, pw), 1);
  endtask

  initial begin
    int v0, e0;
    bus.pwm_in = 1'b0;
    reset_in   = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_speed", bus.speed, 0);
    chk("rst_dir",   bus.direction, 0);
    chk("rst_pw",    bus.pulse_width, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_err",   bus.pulse_err, 0);
    chk("rst_lost",  bus.signal_lost, 1);
    reset_in = 1'b0;
    ticks(10);
    chk("idle_lost",  bus.signal_lost, 1);
    chk("idle_speed", bus.speed, 0);
    chk("idle_vtot",  vtot, 0);
    chk("idle_etot",  etot, 0);

    good("p1500", 1500,   0, 0);
    good("p2000", 2000, 240, 0);
    good("p1000", 1000, 240, 1);
    bad ("p799",   799, 240, 1, 1000);
    good("p800",   800, 255, 1);
    bad ("p2201", 2201, 255, 1, 800);
    good("p2200", 2200, 255, 0);
    good("p1515", 1515,   0, 0);
    good("p1800", 1800, 140, 0);
    bad ("p2300", 2300, 140, 0, 1800);
    chk("p2300_lost", bus.signal_lost, 0);

    // About 2400 ticks have elapsed since the 1800 accept.
    ticks(3400);
    chk("pre_tmo_lost",  bus.signal_lost, 0);
    chk("pre_tmo_speed", bus.speed, 140);
    ticks(400);
    chk("tmo_lost",  bus.signal_lost, 1);
    chk("tmo_speed", bus.speed, 0);
    chk("tmo_dir",   bus.direction, 0);
    chk("tmo_pw",    near(bus.pulse_width, 1800), 1);
    good("rec2000", 2000, 240, 0);

    // Reset mid-pulse, released while the line is still high.
    @(negedge clk_in) bus.pwm_in = 1'b1;
    ticks(700);
    reset_in = 1'b1;
    repeat (4) @(negedge clk_in);
    reset_in = 1'b0;
    ticks(300);
    v0 = vtot; e0 = etot;
    bus.pwm_in = 1'b0;
    repeat (8) @(negedge clk_in);
    chk("rstmid_valid", vtot - v0, 0);
    chk("rstmid_err",   etot - e0, 0);
    chk("rstmid_lost",  bus.signal_lost, 1);
    chk("rstmid_speed", bus.speed, 0);
    ticks(GAP);
    good("p1200", 1200, 140, 1);

    chk("excl", both, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
